// File: rtl/dac_serial_pkg.sv
// Shared types and constants for the DAC serial writer.
package dac_serial_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 4;
  localparam int DATA_BITS  = 12;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LOAD,
    GAP
  } state_t;

  // Command nibble followed by the low 12 bits of the sample; the upper
  // nibble of the sample bus is dropped here.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [CMD_BITS-1:0] cmd,
    input logic [15:0]         value
  );
    return {cmd, value[DATA_BITS-1:0]};
  endfunction

endpackage

// File: rtl/dac_serial_writer_sclk_tick.sv
// Half-period timer for the DAC serial clock. Counts CLK_DIV cycles per
// phase, flags the last cycle of each phase and tracks which phase is active.
module dac_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_phase_end,
  output logic o_high,
  output logic o_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_high;

  assign o_phase_end = i_en && (r_cnt == '0);
  assign o_high      = r_high;
  assign o_fall      = o_phase_end && r_high;

  // Down-counter reloads at terminal count and flips the phase; a clear
  // restarts a fresh low phase.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt  <= RELOAD;
      r_high <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == '0) begin
        r_cnt  <= RELOAD;
        r_high <= ~r_high;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_serial_writer.sv
// SPI-style DAC frame transmitter with a one-deep pending sample buffer.
//
//   state | meaning
//   IDLE  | waiting for a latch rising edge
//   SETUP | cs_dac low, first bit presented, clk_dac low
//   SHIFT | 16 bits, low phase then high phase each, data moves on falls
//   HOLD  | last bit held, clk_dac low, cs_dac still low
//   LOAD  | cs_dac rises, done pulse
//   GAP   | minimum cs_dac high time before the next frame
module dac_serial_writer
  import dac_serial_pkg::*;
#(
  parameter int                  CLK_DIV = 4,
  parameter logic [CMD_BITS-1:0] CMD     = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch,
  input  logic [15:0] value,
  output logic        cs_dac,
  output logic        clk_dac,
  output logic        sdo_dac,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  state_t r_state;
  state_t w_next;

  logic                  r_latch_q;
  logic [FRAME_BITS-1:0] r_shift;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-1:0] r_pend;
  logic                  r_pend_v;
  logic                  r_overrun;

  logic                  w_start;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_phase_end;
  logic                  w_high;
  logic                  w_fall;
  logic                  w_tick_en;
  logic                  w_tick_clr;
  logic                  w_gap_end;

  assign w_start   = latch & ~r_latch_q;
  assign w_frame   = build_frame(CMD, value);
  assign w_gap_end = (r_state == GAP) && w_phase_end;

  // LOAD is excluded from the clear so that LOAD plus GAP together span one
  // full timer period, leaving GAP at CLK_DIV-1 cycles.
  assign w_tick_en  = (r_state != IDLE);
  assign w_tick_clr = (r_state == IDLE) || ((w_next != r_state) && (r_state != LOAD));

  dac_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_tick_en),
    .i_clr       (w_tick_clr),
    .o_phase_end (w_phase_end),
    .o_high      (w_high),
    .o_fall      (w_fall)
  );

  // Edge detector; reset loads the live latch level so a strobe held
  // through reset is not mistaken for a new start.
  always_ff @(posedge clk) begin
    if (reset) r_latch_q <= latch;
    else       r_latch_q <= latch;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and pin decode.
  always_comb begin
    w_next  = r_state;
    cs_dac  = 1'b1;
    clk_dac = 1'b0;
    sdo_dac = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    overrun = r_overrun;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = SETUP;
      end
      SETUP: begin
        cs_dac  = 1'b0;
        sdo_dac = r_shift[FRAME_BITS-1];
        if (w_phase_end) w_next = SHIFT;
      end
      SHIFT: begin
        cs_dac  = 1'b0;
        clk_dac = w_high;
        sdo_dac = r_shift[FRAME_BITS-1];
        if (w_fall && (r_bit == 4'd0)) w_next = HOLD;
      end
      HOLD: begin
        cs_dac  = 1'b0;
        sdo_dac = r_shift[FRAME_BITS-1];
        if (w_phase_end) w_next = LOAD;
      end
      LOAD: begin
        done   = 1'b1;
        w_next = GAP;
      end
      GAP: begin
        if (w_phase_end) w_next = (w_start || r_pend_v) ? SETUP : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Frame shift register: loaded at launch, shifted on each clk_dac fall
  // except the final one so the last bit stays on the pin through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_bit   <= 4'd0;
    end else if (w_start && ((r_state == IDLE) || w_gap_end)) begin
      r_shift <= w_frame;
      r_bit   <= 4'(FRAME_BITS - 1);
    end else if (w_gap_end && r_pend_v) begin
      r_shift <= r_pend;
      r_bit   <= 4'(FRAME_BITS - 1);
    end else if ((r_state == SHIFT) && w_fall && (r_bit != 4'd0)) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      r_bit   <= r_bit - 4'd1;
    end
  end

  // Pending buffer. A start landing on the last GAP cycle is launched
  // directly and still counts as overwriting any sample already waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_gap_end && (w_start || r_pend_v)) begin
        r_pend_v  <= 1'b0;
        r_overrun <= w_start && r_pend_v;
      end else if (w_start && (r_state != IDLE)) begin
        r_pend    <= w_frame;
        r_pend_v  <= 1'b1;
        r_overrun <= r_pend_v;
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_writer.sv
// Scoreboard bench for dac_serial_writer: a timeline model predicts when
// frames launch and what they carry; a monitor reassembles frames from the pins.
module tb_dac_serial_writer;

  localparam int CLK_DIV = 4;
  localparam int CS_LOW  = CLK_DIV + 16 * 2 * CLK_DIV + CLK_DIV;  // 136
  localparam int BUSY    = CS_LOW + CLK_DIV;                      // 140

  logic        clk = 1'b0;
  logic        reset;
  logic        latch;
  logic [15:0] value;
  logic        cs_dac, clk_dac, sdo_dac, busy, done, overrun;

  int checks   = 0;
  int failures = 0;

  dac_serial_writer #(.CLK_DIV(CLK_DIV), .CMD(4'b0011)) dut (
    .clk     (clk),
    .reset   (reset),
    .latch   (latch),
    .value   (value),
    .cs_dac  (cs_dac),
    .clk_dac (clk_dac),
    .sdo_dac (sdo_dac),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (per rising edge) ----------------
  logic [15:0] exp_q[$];
  int          n        = 0;
  int          launch   = -1000;
  int          busy_end = -1000;
  logic        pend_v   = 1'b0;
  logic [15:0] pend_f   = '0;
  logic        prev_latch = 1'b0;
  logic        exp_busy = 1'b0, exp_cs = 1'b1, exp_done = 1'b0, exp_ov = 1'b0;

  always @(posedge clk) begin
    logic        st;
    logic [15:0] f;
    n = n + 1;
    exp_ov = 1'b0;
    if (reset) begin
      pend_v     = 1'b0;
      launch     = -1000;
      busy_end   = -1000;
      prev_latch = latch;
      exp_q.delete();
    end else begin
      st = latch && !prev_latch;
      prev_latch = latch;
      if (st) begin
        f = {4'h3, value[11:0]};
        if (n > busy_end) begin
          exp_q.push_back(f);
          launch   = n;
          busy_end = n + BUSY;
        end else begin
          if (pend_v) exp_ov = 1'b1;
          pend_f = f;
          pend_v = 1'b1;
        end
      end
      if (n == busy_end && pend_v) begin
        exp_q.push_back(pend_f);
        pend_v   = 1'b0;
        launch   = n;
        busy_end = n + BUSY;
      end
    end
    exp_busy = (n < busy_end);
    exp_cs   = !(n >= launch && n < launch + CS_LOW);
    exp_done = (n == launch + CS_LOW);
  end

  // ---------------- monitor (falling edge) ----------------
  logic [15:0] col   = '0;
  int          nbits = 0;
  logic        p_cs = 1'b1, p_clk = 1'b0, p_sdo = 1'b0;

  always @(negedge clk) begin
    logic [5:0]  got, expv;
    logic [15:0] ef;
    if (n > 0) begin
      got  = {busy, cs_dac, done, overrun, cs_dac & sdo_dac, cs_dac & clk_dac};
      expv = {exp_busy, exp_cs, exp_done, exp_ov, 1'b0, 1'b0};
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL ctrl cyc=%0d got=%b expected=%b", n, got, expv);
      end
      if (!cs_dac && clk_dac && !p_clk) begin
        checks++;
        if (sdo_dac !== p_sdo) begin
          failures++;
          $display("FAIL sdo_setup cyc=%0d got=%b expected=%b", n, sdo_dac, p_sdo);
        end
        col = {col[14:0], sdo_dac};
        nbits++;
      end
      if (cs_dac && !p_cs && done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected cyc=%0d got=%h expected=none", n, col);
        end else begin
          ef = exp_q.pop_front();
          if (col !== ef || nbits != 16) begin
            failures++;
            $display("FAIL frame cyc=%0d got=%h bits=%0d expected=%h bits=16", n, col, nbits, ef);
          end
        end
      end
      if (cs_dac) begin
        nbits = 0;
        col   = '0;
      end
      p_cs  = cs_dac;
      p_clk = clk_dac;
      p_sdo = sdo_dac;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [15:0] v, input int hi);
    value = v;
    latch = 1'b1;
    tick(hi);
    latch = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    latch = 1'b0;
    value = '0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // single frame, latch held several cycles
    pulse(16'h0ABC, 5);
    tick(160);

    // upper nibble ignored
    pulse(16'hF800, 1);
    tick(150);
    pulse(16'h0FFF, 2);
    tick(150);

    // one start mid-frame
    pulse(16'h0456, 1);
    tick(50);
    pulse(16'h0123, 1);
    tick(300);

    // two starts mid-frame: overrun, newest wins
    pulse(16'h0333, 1);
    tick(30);
    pulse(16'h0111, 1);
    tick(20);
    pulse(16'h0222, 1);
    tick(400);

    // reset during bit 7 of SHIFT
    value = 16'h0555;
    latch = 1'b1;
    tick(1);
    latch = 1'b0;
    tick(70);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    pulse(16'h0777, 1);
    tick(160);

    // latch held across reset release
    latch = 1'b1;
    value = 16'h0999;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    latch = 1'b0;
    tick(2);
    pulse(16'h0AAA, 1);
    tick(160);

    // start exactly on the last GAP cycle, with and without a waiting sample
    pulse(16'h0C01, 1);
    tick(BUSY - 2);
    pulse(16'h0C02, 1);
    tick(300);
    pulse(16'h0C03, 1);
    tick(20);
    pulse(16'h0C04, 1);
    tick(BUSY - 24);
    pulse(16'h0C05, 1);
    tick(300);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      pulse(16'($urandom), $urandom_range(1, 4));
      tick($urandom_range(0, 200));
    end

    tick(4 * BUSY);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d frames outstanding expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
